game_control_fsm: RTL
=====================

// Module: game_control_fsm
// PURPOSE
//  Top-level sequencer directly upstream of the game datapath. It issues one
//  state-enable strobe per phase, in this order: init, idle, move generation,
//  collision check, link/enemy apply, map/link/enemy draw. It advances on the
//  datapath's *_done handshakes.
//  A per-state watchdog stops a missing done from hanging the frame loop.
//  It also counts completed frames.
// PARAMETERS
//  TO_W          20          width of watchdog counter
//  WAIT_TIMEOUT  20'hFFFFF   max cycles in any done-waiting state before forced advance
//  FC_W          16          width of frame_count
// PORTS
//  clock               in   1     system clock (CLOCK_50)
//  reset               in   1     synchronous, active-high
//  pause               in   1     hold in S_IDLE while high
//  idle_done           in   1     frame-rate tick done, from datapath
//  gen_move_done       in   1     enemy move generation done
//  check_collide_done  in   1     collision detector done
//  draw_map_done       in   1     map draw done
//  draw_link_done      in   1     link sprite draw done
//  draw_enemies_done   in   1     enemy sprite draw done
//  init                out  1     strobe: initialise datapath registers
//  idle                out  1     high in S_IDLE
//  gen_move            out  1     high in S_GEN_MOVE
//  check_collide       out  1     high in S_CHECK_COLLIDE
//  apply_act_link      out  1     high in S_APPLY_LINK
//  move_enemies        out  1     high in S_MOVE_ENEMIES
//  draw_map            out  1     high in S_DRAW_MAP
//  draw_link           out  1     high in S_DRAW_LINK
//  draw_enemies        out  1     high in S_DRAW_ENEMIES
//  frame_count         out  FC_W  completed frames; wraps modulo 2^FC_W
//  timeout_err         out  1     sticky: a watchdog forced an advance
//  state_dbg           out  4     current state encoding
// BEHAVIOUR
//  - Clock is clock; reset is reset, synchronous, active-high, and overrides everything.
//  - Moore machine. Every enable output is a registered decode of state, so at
//    most one enable is high in any cycle.
//  - Reset values: state = S_INIT, init = 1, all other enables = 0,
//    frame_count = 0, timeout_err = 0, watchdog = 0, entry = 1.
//  - States and transitions:
//    S_INIT(0)        -> S_DRAW_MAP after 1 cycle; full screen is painted before play.
//    S_IDLE(1)        -> S_GEN_MOVE when idle_done && !pause.
//    S_GEN_MOVE(2)    -> S_CHECK_COLLIDE on gen_move_done.
//    S_CHECK_COLLIDE(3) -> S_APPLY_LINK on check_collide_done.
//    S_APPLY_LINK(4)  -> S_MOVE_ENEMIES after exactly 1 cycle.
//    S_MOVE_ENEMIES(5) -> S_DRAW_MAP after exactly 1 cycle.
//    S_DRAW_MAP(6)    -> S_DRAW_LINK on draw_map_done.
//    S_DRAW_LINK(7)   -> S_DRAW_ENEMIES on draw_link_done.
//    S_DRAW_ENEMIES(8) -> S_IDLE on draw_enemies_done; frame_count increments on this edge.
//    Codes 9-15       -> S_INIT (recovery).
//  - Entry guard: the "entry" flag is set on every state change and clears one
//    cycle later. A done input is ignored while entry = 1, so a stale done from
//    the previous phase cannot skip a state. The minimum dwell in any wait state
//    is therefore 2 cycles.
//  - Watchdog:
//    - Clears on every state change.
//    - Increments each cycle in the wait states GEN_MOVE, CHECK_COLLIDE and the three DRAW states.
//    - When it reaches WAIT_TIMEOUT-1, the FSM takes that state's normal
//      successor and sets timeout_err. timeout_err stays set until reset.
//    - The watchdog is not active in S_IDLE. pause may hold S_IDLE indefinitely.
//  - Simultaneous events: done and timeout in the same cycle count as a normal
//    advance; timeout_err is not set. pause only gates the IDLE exit.
//  - Reset mid-frame: the next cycle is S_INIT with init = 1. The datapath
//    drops its in-progress draw because draw_* goes low.
//  - frame_count wraps from 2^FC_W-1 to 0 without a flag.
// STRUCTURE
//  - Shared package game_pkg:
//    - state enum / localparams S_INIT..S_DRAW_ENEMIES (4-bit)
//    - action codes NO_ACTION..RIGHT, which the datapath also uses
//  - Sub-module state_watchdog (counter, clear, enable, expired), sized by TO_W.
//  - Next-state logic is combinational; state, entry flag and outputs are registered.
// TESTING
//  1 Reset 3 cycles, then release -> init = 1 for 1 cycle, then draw_map = 1;
//    frame_count = 0.
//  2 Full loop: pulse each done 3 cycles after its enable rises -> enables
//    sequence IDLE..DRAW_ENEMIES, apply_act_link and move_enemies are 1 cycle
//    each, and frame_count goes 0 -> 1.
//  3 Hold draw_map_done = 1 continuously into S_DRAW_LINK entry -> draw_link
//    stays high for at least 2 cycles; there is no skip to S_DRAW_ENEMIES.
//  4 WAIT_TIMEOUT = 16 and gen_move_done never asserted -> S_CHECK_COLLIDE is
//    entered 16 cycles after S_GEN_MOVE entry, and timeout_err = 1 and sticks.
//  5 pause = 1 with idle_done pulsing -> the FSM stays in S_IDLE. Dropping
//    pause -> S_GEN_MOVE on the next idle_done.
//  6 Assert reset while in S_DRAW_LINK -> next cycle state_dbg = 0 and init = 1;
//    frame_count = 0 and timeout_err = 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and datapath.
//   state_e      : 4-bit sequencer state codes (S_INIT..S_DRAW_ENEMIES)
//   action_e     : player/enemy action codes, also used by the datapath
//   state_onehot : enable-strobe decode of a state (bit i <-> state code i)
package game_pkg;

  typedef enum logic [3:0] {
    S_INIT          = 4'd0,
    S_IDLE          = 4'd1,
    S_GEN_MOVE      = 4'd2,
    S_CHECK_COLLIDE = 4'd3,
    S_APPLY_LINK    = 4'd4,
    S_MOVE_ENEMIES  = 4'd5,
    S_DRAW_MAP      = 4'd6,
    S_DRAW_LINK     = 4'd7,
    S_DRAW_ENEMIES  = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    NO_ACTION = 3'd0,
    UP        = 3'd1,
    DOWN      = 3'd2,
    LEFT      = 3'd3,
    RIGHT     = 3'd4
  } action_e;

  localparam int unsigned N_STATES = 9;

  // Codes above S_DRAW_ENEMIES shift out and decode to all-zero.
  function automatic logic [N_STATES-1:0] state_onehot(input state_e s);
    return N_STATES'(1) << s;
  endfunction

endpackage

// File: rtl/state_watchdog.sv
// Per-state watchdog counter.
//   clock, reset : clock and synchronous active-high reset
//   clear_i      : zero the count (state change)
//   enable_i     : count this cycle (done-waiting state)
//   expired_o    : count has reached LIMIT-1 while enabled
module state_watchdog #(
  parameter int unsigned     TO_W  = 20,
  parameter logic [TO_W-1:0] LIMIT = '1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = LIMIT - TO_W'(1);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + TO_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/game_control_fsm.sv
// Frame-loop sequencer for the game datapath. Issues one registered enable
// per phase and advances on the datapath's *_done handshakes, with a
// per-state watchdog that forces the normal successor if a done never comes.
//   clock, reset         : clock, synchronous active-high reset
//   pause                : holds the FSM in S_IDLE
//   *_done               : phase-complete handshakes from the datapath
//   init .. draw_enemies : one-hot phase enables (registered state decode)
//   frame_count          : completed frames, wraps
//   timeout_err          : sticky, set when the watchdog forced an advance
//   state_dbg            : current state code
//
// state           | meaning
// S_INIT          | initialise datapath registers, one cycle
// S_IDLE          | wait for frame tick (blocked by pause)
// S_GEN_MOVE      | enemy move generation
// S_CHECK_COLLIDE | collision detection
// S_APPLY_LINK    | apply link action, one cycle
// S_MOVE_ENEMIES  | apply enemy moves, one cycle
// S_DRAW_MAP      | draw background map
// S_DRAW_LINK     | draw link sprite
// S_DRAW_ENEMIES  | draw enemy sprites, frame ends
module game_control_fsm
  import game_pkg::*;
#(
  parameter int unsigned     TO_W         = 20,
  parameter logic [TO_W-1:0] WAIT_TIMEOUT = 20'hFFFFF,
  parameter int unsigned     FC_W         = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pause,
  input  logic            idle_done,
  input  logic            gen_move_done,
  input  logic            check_collide_done,
  input  logic            draw_map_done,
  input  logic            draw_link_done,
  input  logic            draw_enemies_done,
  output logic            init,
  output logic            idle,
  output logic            gen_move,
  output logic            check_collide,
  output logic            apply_act_link,
  output logic            move_enemies,
  output logic            draw_map,
  output logic            draw_link,
  output logic            draw_enemies,
  output logic [FC_W-1:0] frame_count,
  output logic            timeout_err,
  output logic [3:0]      state_dbg
);

  state_e                state_q, state_d, succ;
  logic                  entry_q;
  logic [N_STATES-1:0]   en_q;
  logic [FC_W-1:0]       frame_count_q;
  logic                  timeout_err_q;
  logic                  auto_adv, wait_st, done_sel;
  logic                  set_err, frame_inc, state_chg, wd_expired;

  state_watchdog #(
    .TO_W  (TO_W),
    .LIMIT (WAIT_TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (state_chg),
    .enable_i  (wait_st),
    .expired_o (wd_expired)
  );

  // Per-state successor and which handshake (if any) releases it.
  always_comb begin
    succ     = S_INIT;
    auto_adv = 1'b0;
    wait_st  = 1'b0;
    done_sel = 1'b0;
    case (state_q)
      S_INIT:          begin succ = S_DRAW_MAP;      auto_adv = 1'b1; end
      S_IDLE:          begin succ = S_GEN_MOVE;      done_sel = idle_done && !pause; end
      S_GEN_MOVE:      begin succ = S_CHECK_COLLIDE; done_sel = gen_move_done;      wait_st = 1'b1; end
      S_CHECK_COLLIDE: begin succ = S_APPLY_LINK;    done_sel = check_collide_done; wait_st = 1'b1; end
      S_APPLY_LINK:    begin succ = S_MOVE_ENEMIES;  auto_adv = 1'b1; end
      S_MOVE_ENEMIES:  begin succ = S_DRAW_MAP;      auto_adv = 1'b1; end
      S_DRAW_MAP:      begin succ = S_DRAW_LINK;     done_sel = draw_map_done;      wait_st = 1'b1; end
      S_DRAW_LINK:     begin succ = S_DRAW_ENEMIES;  done_sel = draw_link_done;     wait_st = 1'b1; end
      S_DRAW_ENEMIES:  begin succ = S_IDLE;          done_sel = draw_enemies_done;  wait_st = 1'b1; end
      default:         begin succ = S_INIT;          auto_adv = 1'b1; end
    endcase
  end

  // A done seen in the first cycle of a state may be left over from the
  // previous phase, so it is masked by entry_q. A real done wins over a
  // simultaneous watchdog expiry, so the error flag is not raised then.
  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    if (auto_adv) begin
      state_d = succ;
    end else if (done_sel && !entry_q) begin
      state_d = succ;
    end else if (wd_expired) begin
      state_d = succ;
      set_err = 1'b1;
    end
    state_chg = (state_d != state_q);
    frame_inc = (state_q == S_DRAW_ENEMIES) && (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_INIT;
      entry_q       <= 1'b1;
      en_q          <= state_onehot(S_INIT);
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= state_chg;
      en_q    <= state_onehot(state_d);
      if (frame_inc) frame_count_q <= frame_count_q + FC_W'(1);
      if (set_err)   timeout_err_q <= 1'b1;
    end
  end

  assign init           = en_q[S_INIT];
  assign idle           = en_q[S_IDLE];
  assign gen_move       = en_q[S_GEN_MOVE];
  assign check_collide  = en_q[S_CHECK_COLLIDE];
  assign apply_act_link = en_q[S_APPLY_LINK];
  assign move_enemies   = en_q[S_MOVE_ENEMIES];
  assign draw_map       = en_q[S_DRAW_MAP];
  assign draw_link      = en_q[S_DRAW_LINK];
  assign draw_enemies   = en_q[S_DRAW_ENEMIES];
  assign frame_count    = frame_count_q;
  assign timeout_err    = timeout_err_q;
  assign state_dbg      = state_q;

endmodule
